display_mux_14seg: RTL and testbench



---
 rtl/display_mux_14seg_pkg.sv | 21 ++
 rtl/display_mux_14seg_scan_prescaler.sv | 29 ++
 rtl/display_mux_14seg.sv | 135 +++++++++++++
 tb/tb_display_mux_14seg.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_mux_14seg_pkg.sv
// Shared constants, state encoding and a width helper for the 14-segment display multiplexer.
package display_mux_14seg_pkg;

  localparam logic [7:0] CHAR_BLANK = 8'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/display_mux_14seg_scan_prescaler.sv
// Free-running slot counter: counts 0..PERIOD-1 and flags the last count of each digit slot.
module scan_prescaler
  import display_mux_14seg_pkg::*;
#(
  parameter int PERIOD  = 10,
  parameter int COUNT_W = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Clear_i,
  output logic [COUNT_W-1:0] Count_o,
  output logic               Terminal_o
);

  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(PERIOD - 1);

  assign Terminal_o = (Count_o == LAST_COUNT);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Count_o <= '0;
    end else if (Clear_i || Terminal_o) begin
      Count_o <= '0;
    end else begin
      Count_o <= Count_o + 1'b1;
    end
  end

endmodule

// File: rtl/display_mux_14seg.sv
// Digit scanner feeding the shared 14-segment decoder: character buffer, blank/show
// sequencing per digit slot and an end-of-frame pulse.
module display_mux_14seg
  import display_mux_14seg_pkg::*;
#(
  parameter int DIGITS             = 4,
  parameter int CLOCK_HZ           = 25000000,
  parameter int SCAN_HZ            = 1000,
  parameter int BLANK_CYCLES       = 16,
  parameter bit SELECT_ACTIVE_HIGH = 1'b1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Enable_i,
  input  logic                      WriteEnable_i,
  input  logic [clog2(DIGITS)-1:0]  WriteAddr_i,
  input  logic [7:0]                WriteData_i,
  output logic [7:0]                Data_o,
  output logic                      DecoderEnable_o,
  output logic [DIGITS-1:0]         Digit_o,
  output logic                      FrameDone_o
);

  localparam int PERIOD  = CLOCK_HZ / SCAN_HZ;
  localparam int IDX_W   = clog2(DIGITS);
  localparam int COUNT_W = (clog2(PERIOD) < 1) ? 1 : clog2(PERIOD);

  localparam logic [IDX_W-1:0]   LAST_INDEX = IDX_W'(DIGITS - 1);
  localparam logic [COUNT_W-1:0] BLANK_LAST = COUNT_W'(BLANK_CYCLES - 1);
  localparam logic [DIGITS-1:0]  DIGIT_OFF  = SELECT_ACTIVE_HIGH ? {DIGITS{1'b0}} : {DIGITS{1'b1}};

  scan_state_t        state;
  logic [IDX_W-1:0]   index;
  logic [IDX_W-1:0]   next_index;
  logic [COUNT_W-1:0] count;
  logic               terminal;
  logic               prescaler_clear;
  logic [7:0]         char_buf [DIGITS];

  function automatic logic [DIGITS-1:0] digit_select(input logic [IDX_W-1:0] idx);
    logic [DIGITS-1:0] onehot;
    onehot      = '0;
    onehot[idx] = 1'b1;
    return SELECT_ACTIVE_HIGH ? onehot : ~onehot;
  endfunction

  // The slot counter only runs while scanning, so every scan starts at a slot boundary.
  assign prescaler_clear = !Enable_i || (state == IDLE);
  assign next_index      = (index == LAST_INDEX) ? '0 : index + 1'b1;

  scan_prescaler #(
    .PERIOD  (PERIOD),
    .COUNT_W (COUNT_W)
  ) u_prescaler (
    .Clock      (Clock),
    .Reset      (Reset),
    .Clear_i    (prescaler_clear),
    .Count_o    (count),
    .Terminal_o (terminal)
  );

  // Out-of-range addresses simply match no entry.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < DIGITS; k++) begin
        char_buf[k] <= CHAR_BLANK;
      end
    end else if (WriteEnable_i) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (WriteAddr_i == IDX_W'(k)) begin
          char_buf[k] <= WriteData_i;
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state           <= IDLE;
      index           <= '0;
      Data_o          <= CHAR_BLANK;
      DecoderEnable_o <= 1'b0;
      Digit_o         <= DIGIT_OFF;
      FrameDone_o     <= 1'b0;
    end else begin
      FrameDone_o <= 1'b0;
      if (!Enable_i) begin
        state           <= IDLE;
        index           <= '0;
        Data_o          <= CHAR_BLANK;
        DecoderEnable_o <= 1'b0;
        Digit_o         <= DIGIT_OFF;
      end else begin
        case (state)
          IDLE: begin
            state           <= BLANK;
            index           <= '0;
            Data_o          <= char_buf[0];
            DecoderEnable_o <= 1'b0;
            Digit_o         <= DIGIT_OFF;
          end
          BLANK: begin
            Data_o <= char_buf[index];
            if (count == BLANK_LAST) begin
              state           <= SHOW;
              DecoderEnable_o <= 1'b1;
              Digit_o         <= digit_select(index);
            end
          end
          SHOW: begin
            if (terminal) begin
              // Data for the next digit is presented already during its blank gap.
              state           <= BLANK;
              index           <= next_index;
              Data_o          <= char_buf[next_index];
              DecoderEnable_o <= 1'b0;
              Digit_o         <= DIGIT_OFF;
              FrameDone_o     <= (index == LAST_INDEX);
            end else begin
              Data_o <= char_buf[index];
            end
          end
          default: begin
            state           <= IDLE;
            index           <= '0;
            Data_o          <= CHAR_BLANK;
            DecoderEnable_o <= 1'b0;
            Digit_o         <= DIGIT_OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_mux_14seg.sv
// Scoreboard bench for display_mux_14seg: three instances (4 digits active-high,
// 4 digits active-low, 3 digits active-high) with PERIOD = 10 and 2 blank cycles.
module tb_display_mux_14seg;

  typedef struct {
    int         dut;
    int         t;
    logic [3:0] digit;
    logic       de;
    logic [7:0] data;
    logic       fd;
    string      tag;
  } exp_t;

  logic       Clock;
  logic       Reset;
  logic       en, we;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic       en2, we2;
  logic [1:0] waddr2;
  logic [7:0] wdata2;

  logic [7:0] d0_data, d1_data, d2_data;
  logic       d0_de, d1_de, d2_de;
  logic [3:0] d0_digit, d1_digit;
  logic [2:0] d2_digit;
  logic       d0_fd, d1_fd, d2_fd;

  exp_t       sb_q [$];
  logic [7:0] m0 [4];
  logic [7:0] m2 [4];
  int         compared;
  int         mismatched;

  display_mux_14seg #(
    .DIGITS(4), .CLOCK_HZ(100), .SCAN_HZ(10), .BLANK_CYCLES(2), .SELECT_ACTIVE_HIGH(1'b1)
  ) dut0 (
    .Clock(Clock), .Reset(Reset), .Enable_i(en), .WriteEnable_i(we),
    .WriteAddr_i(waddr), .WriteData_i(wdata), .Data_o(d0_data),
    .DecoderEnable_o(d0_de), .Digit_o(d0_digit), .FrameDone_o(d0_fd)
  );

  display_mux_14seg #(
    .DIGITS(4), .CLOCK_HZ(100), .SCAN_HZ(10), .BLANK_CYCLES(2), .SELECT_ACTIVE_HIGH(1'b0)
  ) dut1 (
    .Clock(Clock), .Reset(Reset), .Enable_i(en), .WriteEnable_i(we),
    .WriteAddr_i(waddr), .WriteData_i(wdata), .Data_o(d1_data),
    .DecoderEnable_o(d1_de), .Digit_o(d1_digit), .FrameDone_o(d1_fd)
  );

  display_mux_14seg #(
    .DIGITS(3), .CLOCK_HZ(100), .SCAN_HZ(10), .BLANK_CYCLES(2), .SELECT_ACTIVE_HIGH(1'b1)
  ) dut2 (
    .Clock(Clock), .Reset(Reset), .Enable_i(en2), .WriteEnable_i(we2),
    .WriteAddr_i(waddr2), .WriteData_i(wdata2), .Data_o(d2_data),
    .DecoderEnable_o(d2_de), .Digit_o(d2_digit), .FrameDone_o(d2_fd)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Expected outputs t cycles after the enabling edge, from slot = t/10 and phase = t%10.
  function automatic exp_t modelCycle(input int dut, input int t, input int ndig, input bit hi,
                                      input logic [7:0] b [4], input string tag);
    exp_t       e;
    int         slot;
    int         phase;
    logic [3:0] onehot;
    logic [3:0] mask;
    slot   = (t / 10) % ndig;
    phase  = t % 10;
    onehot = 4'b0000;
    mask   = (ndig == 3) ? 4'b0111 : 4'b1111;
    if (phase >= 2) onehot = 4'b0001 << slot;
    e.dut   = dut;
    e.t     = t;
    e.digit = hi ? onehot : (~onehot & mask);
    e.de    = (phase >= 2);
    e.data  = b[slot];
    e.fd    = (phase == 0) && (slot == 0) && (t > 0);
    e.tag   = tag;
    return e;
  endfunction

  function automatic exp_t offExp(input int dut, input string tag);
    exp_t e;
    e.dut   = dut;
    e.t     = -1;
    e.digit = (dut == 1) ? 4'b1111 : 4'b0000;
    e.de    = 1'b0;
    e.data  = 8'h00;
    e.fd    = 1'b0;
    e.tag   = tag;
    return e;
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [3:0] a_digit;
    logic       a_de;
    logic [7:0] a_data;
    logic       a_fd;
    case (e.dut)
      0: begin a_digit = d0_digit; a_de = d0_de; a_data = d0_data; a_fd = d0_fd; end
      1: begin a_digit = d1_digit; a_de = d1_de; a_data = d1_data; a_fd = d1_fd; end
      default: begin a_digit = {1'b0, d2_digit}; a_de = d2_de; a_data = d2_data; a_fd = d2_fd; end
    endcase
    compared++;
    if (a_digit !== e.digit || a_de !== e.de || a_data !== e.data || a_fd !== e.fd) begin
      mismatched++;
      $display("[TB] FAIL %s dut%0d t=%0d: got digit=%b de=%b data=%h fd=%b, expected digit=%b de=%b data=%h fd=%b",
               e.tag, e.dut, e.t, a_digit, a_de, a_data, a_fd, e.digit, e.de, e.data, e.fd);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge Clock);
      while (sb_q.size() > 0) begin
        checkOutput(sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic w, input logic [1:0] a, input logic [7:0] d);
    en    = e;
    we    = w;
    waddr = a;
    wdata = d;
  endtask

  task automatic pushPairOff(input string tag);
    sb_q.push_back(offExp(0, tag));
    sb_q.push_back(offExp(1, tag));
  endtask

  // Runs n enabled cycles from the enabling edge; optionally writes wr_d to wr_a during cycle wr_t.
  task automatic runChecked(input int n, input int wr_t, input logic [1:0] wr_a,
                            input logic [7:0] wr_d, input string tag);
    for (int t = 0; t < n; t++) begin
      step();
      if (t == wr_t + 2) m0[wr_a] = wr_d;
      sb_q.push_back(modelCycle(0, t, 4, 1'b1, m0, tag));
      sb_q.push_back(modelCycle(1, t, 4, 1'b0, m0, tag));
      if (t == wr_t) applyStimulus(1'b1, 1'b1, wr_a, wr_d);
      else           applyStimulus(1'b1, 1'b0, 2'd0, 8'h00);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < 4; i++) begin
      m0[i] = 8'h00;
      m2[i] = 8'h00;
    end
    Reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
    en2 = 1'b0; we2 = 1'b0; waddr2 = 2'd0; wdata2 = 8'h00;

    #1 Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      pushPairOff("reset");
      sb_q.push_back(offExp(2, "reset"));
    end
    Reset = 1'b0;
    step();
    pushPairOff("idle");

    $display("[TB] scan with empty buffer");
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h00);
    runChecked(45, -10, 2'd0, 8'h00, "scan_empty");

    $display("[TB] writes while disabled, then scan with live update of digit 2");
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
    step(); pushPairOff("disable");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 2'(i), 8'h41 + 8'(i));
      step();
      pushPairOff("write_idle");
      m0[i] = 8'h41 + 8'(i);
    end
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h00);
    runChecked(56, 24, 2'd2, 8'h5A, "scan_chars");

    $display("[TB] drop enable during digit 1, then re-enable");
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
    step(); pushPairOff("drop_enable");
    step(); pushPairOff("drop_enable");
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h00);
    runChecked(15, -10, 2'd0, 8'h00, "reenable");

    $display("[TB] asynchronous reset mid-frame");
    step();
    pushPairOff("async_reset");
    #1 Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 4; i++) m0[i] = 8'h00;
    step(); pushPairOff("reset_hold");
    Reset = 1'b0;
    step(); pushPairOff("reset_release");
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h00);
    runChecked(42, -10, 2'd0, 8'h00, "after_reset");

    $display("[TB] three-digit instance with an out-of-range write");
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00);
    step(); pushPairOff("idle_again");
    for (int i = 0; i < 4; i++) begin
      we2    = 1'b1;
      waddr2 = 2'(i);
      wdata2 = (i == 3) ? 8'h77 : 8'h11 * 8'(i + 1);
      step();
      sb_q.push_back(offExp(2, "d3_write"));
      pushPairOff("d3_write");
      if (i < 3) m2[i] = 8'h11 * 8'(i + 1);
    end
    we2 = 1'b0;
    en2 = 1'b1;
    for (int t = 0; t < 35; t++) begin
      step();
      sb_q.push_back(modelCycle(2, t, 3, 1'b1, m2, "d3_scan"));
      pushPairOff("d3_other_idle");
    end
    en2 = 1'b0;

    @(negedge Clock);
    #1;
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
